// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: serial receiver with a programmable baud-tick generator, a configurable
// frame format (DATA_BITS data bits, optional parity, one stop bit) and a
// first-word-fall-through receive FIFO with sticky error flags.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-low reset
//   rxd        asynchronous serial input, idle high
//   div_wr     load div_data into the divisor and reload the tick counter
//   div_data   new divisor; tick period is divisor+1 clocks
//   rd_en      pop the head word (ignored when empty)
//   rd_data    head word, zero-extended to 8 bits; 0 when empty
//   rda        FIFO not empty
//   count      number of words held
//   frame_err  sticky: stop bit sampled low
//   parity_err sticky: parity mismatch
//   overrun    sticky: word dropped because the FIFO was full
//   err_clr    clear the three sticky flags (a same-cycle set event wins)

module spart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DIV_RESET  = 325,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          div_wr,
    input  logic [DIV_WIDTH-1:0]          div_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rda,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SMID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BLAST = 3'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic          ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;

    // ---------------------------------------------------------------- synchronizer
    logic rx_meta_q, rxs_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------- tick generator
    logic [DIV_WIDTH-1:0] div_q, tcnt_q;
    logic                 tick;

    assign tick = (tcnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= DIV_WIDTH'(DIV_RESET);
            tcnt_q <= '0;
        end else if (div_wr) begin
            div_q  <= div_data;
            tcnt_q <= div_data;
        end else if (tick) begin
            tcnt_q <= div_q;
        end else begin
            tcnt_q <= tcnt_q - 1'b1;
        end
    end

    // ---------------------------------------------------------------- receive FSM
    state_e               state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic                 push, frame_set, parity_set;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            scnt_q    <= '0;
            bidx_q    <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bidx_d     = bidx_q;
        shreg_d    = shreg_q;
        par_bad_d  = par_bad_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick && !rxs_q) begin
                    state_d = StStart;
                    scnt_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    // Half a bit in: a high line means the falling edge was noise.
                    if (scnt_q == SMID) begin
                        if (rxs_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d   = StData;
                            scnt_d    = '0;
                            bidx_d    = '0;
                            par_bad_d = 1'b0;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (scnt_q == SLAST) begin
                        scnt_d  = '0;
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == BLAST) begin
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    if (scnt_q == SLAST) begin
                        scnt_d    = '0;
                        par_bad_d = ((^shreg_q) ^ rxs_q) != ODD;
                        state_d   = StStop;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (scnt_q == SLAST) begin
                        scnt_d = '0;
                        if (!rxs_q) begin
                            frame_set = 1'b1;
                            state_d   = StBrk;
                        end else begin
                            if (par_bad_q) parity_set = 1'b1;
                            else           push       = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StBrk: begin
                // Hold off until the line returns high so a break cannot retrigger.
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          cnt_q;
    logic                 pop, full, wr, drop;

    assign pop  = rd_en && (cnt_q != '0);
    assign full = (cnt_q == FULL);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            unique case ({wr, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (cnt_q != '0) rd_data[DATA_BITS-1:0] = mem_q[rptr_q];
    end

    assign rda   = (cnt_q != '0);
    assign count = cnt_q;

    // ---------------------------------------------------------------- sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= (frame_err  & ~err_clr) | frame_set;
            parity_err <= (parity_err & ~err_clr) | parity_set;
            overrun    <= (overrun    & ~err_clr) | drop;
        end
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Self-checking bench for spart_rx_fifo: 8E1 frames, FIFO_DEPTH=4, divisor 3 (64 clocks/bit).
`timescale 1ns/1ps

module tb_spart_rx_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        div_wr = 1'b0;
    logic [15:0] div_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rda;
    logic [2:0]  count;
    logic        frame_err, parity_err, overrun;
    logic        err_clr = 1'b0;

    spart_rx_fifo #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(DEPTH),
        .DIV_WIDTH (16),
        .DIV_RESET (7),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .div_wr    (div_wr),
        .div_data  (div_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rda       (rda),
        .count     (count),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: the frame-level rules applied to a queue and three flags.
    logic [7:0] q[$];
    logic       m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0;
    int         push_ref = -1;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic m_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop)                    m_fe = 1'b1;
        else if (par != even_par(d))  m_pe = 1'b1;
        else if (q.size() < DEPTH)    q.push_back(d);
        else                          m_ov = 1'b1;
    endtask

    task automatic m_pop();
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic m_clr();
        m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        chk({name, " count"},      32'(count),      32'(q.size()));
        chk({name, " rda"},        32'(rda),        32'(q.size() != 0));
        chk({name, " rd_data"},    32'(rd_data),    32'(head));
        chk({name, " frame_err"},  32'(frame_err),  32'(m_fe));
        chk({name, " parity_err"}, 32'(parity_err), 32'(m_pe));
        chk({name, " overrun"},    32'(overrun),    32'(m_ov));
    endtask

    // Drives one 8E1 frame. pop_at/clr_at pulse rd_en/err_clr on that frame clock; push_off
    // reports the frame clock whose edge changed count (used to time coincident events).
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int bit_clks, input int pop_at, input int clr_at,
                              input int tail_low, output int push_off);
        logic [10:0] fr;
        logic [2:0]  prev;
        fr = {stop, par, d, 1'b0};
        while (cyc % 4 != 0) @(negedge clk);
        push_off = -1;
        prev = count;
        for (int i = 0; i < 11 * bit_clks; i++) begin
            rxd     = fr[i / bit_clks];
            rd_en   = (i == pop_at);
            err_clr = (i == clr_at);
            @(negedge clk);
            if (push_off < 0 && count != prev) push_off = i;
        end
        rd_en   = 1'b0;
        err_clr = 1'b0;
        if (tail_low > 0) begin
            rxd = 1'b0;
            repeat (tail_low) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (16) @(negedge clk);
        if (pop_at < 0 && push_off >= 0) push_ref = push_off;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop);
        int po;
        send_frame(d, par, stop, 64, -1, -1, 0, po);
        m_frame(d, par, stop);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        m_pop();
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_clr();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_fe;
        logic       exp_pe;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         po;
        logic [7:0] exp_rd[4];
        logic [7:0] d;
        logic       p, s;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h03, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 2, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h12, 1'b0, 1'b1, 3, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h07, 1'b1, 1'b1, 4, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b1, 4, 8'hA5, 1'b1, 1'b1, 1'b1};
        exp_rd = '{8'hA5, 8'h03, 8'h12, 8'h07};

        // Reset values.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_model("reset");

        div_wr   = 1'b1;
        div_data = 16'd3;
        @(negedge clk);
        div_wr = 1'b0;

        // Table: frames from an empty FIFO, hand-computed expectations.
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 64, -1, -1, 0, po);
            m_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            chk($sformatf("tbl[%0d] count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl[%0d] head", i), 32'(rd_data), 32'(tbl[i].exp_head));
            chk($sformatf("tbl[%0d] frame_err", i), 32'(frame_err), 32'(tbl[i].exp_fe));
            chk($sformatf("tbl[%0d] parity_err", i), 32'(parity_err), 32'(tbl[i].exp_pe));
            chk($sformatf("tbl[%0d] overrun", i), 32'(overrun), 32'(tbl[i].exp_ov));
        end

        // Drain in order, then pop while empty.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain[%0d] head", i), 32'(rd_data), 32'(exp_rd[i]));
            do_pop();
        end
        check_model("drained");
        do_pop();
        check_model("pop empty");
        do_clr();
        check_model("err_clr");

        // Start glitch.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check_model("glitch");
        send(8'h3C, 1'b0, 1'b1);
        check_model("after glitch");
        do_pop();

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, 1'b0, 64, -1, -1, 500, po);
        m_frame(8'h55, 1'b0, 1'b0);
        check_model("break");
        send(8'h12, 1'b0, 1'b1);
        check_model("after break");
        do_pop();

        // Clear coincident with a new framing error: the set wins.
        send(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0, 64, -1, push_ref, 0, po);
        m_clr();
        m_frame(8'h01, 1'b1, 1'b0);
        check_model("clr vs set");
        do_clr();

        // Overrun and pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 6; v++) begin
                d = 8'(v);
                send(d, even_par(d), 1'b1);
                check_model($sformatf("wrap r%0d v%0d", r, v));
            end
            for (int k = 0; k < 4; k++) begin
                do_pop();
                check_model($sformatf("wrap r%0d rd%0d", r, k));
            end
            do_clr();
        end

        // Push coincident with a pop while full.
        for (int v = 0; v < 4; v++) begin
            d = 8'h10 + 8'(v);
            send(d, even_par(d), 1'b1);
        end
        check_model("full");
        send_frame(8'h20, 1'b1, 1'b1, 64, push_ref, -1, 0, po);
        m_pop();
        m_frame(8'h20, 1'b1, 1'b1);
        check_model("full push+pop");
        for (int k = 0; k < 4; k++) begin
            do_pop();
            check_model($sformatf("full rd%0d", k));
        end

        // Randomized frames against the model.
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            p = even_par(d) ^ ($urandom_range(0, 4) == 0);
            s = ($urandom_range(0, 9) != 0);
            send(d, p, s);
            check_model($sformatf("rnd%0d", n));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                do_pop();
                check_model($sformatf("rnd%0d rd", n));
            end
            if ($urandom_range(0, 3) == 0) do_clr();
        end

        // Reset mid-frame: leave state behind, abandon a frame during data bit 3.
        send(8'h0F, 1'b1, 1'b1);
        send(8'h0F, 1'b0, 1'b1);
        d = 8'h6B;
        while (cyc % 4 != 0) @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rxd = d[k];
            repeat (64) @(negedge clk);
        end
        rxd = d[3];
        repeat (32) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        q.delete();
        m_clr();
        check_model("rst mid");
        repeat (1500) @(negedge clk);
        check_model("rst settle");
        // Divisor is back at DIV_RESET=7: 128 clocks per bit.
        send_frame(8'h5A, 1'b0, 1'b1, 128, -1, -1, 0, po);
        m_frame(8'h5A, 1'b0, 1'b1);
        check_model("after rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spart_rx_fifo.md
# spart_rx_fifo

Parametrised successor to the SPART receive path: a serial receiver with a built-in programmable baud-tick generator, configurable frame format (5–8 data bits, optional parity) and a first-word-fall-through receive FIFO with sticky error flags. It sits between the board `rxd` pin and the processor-side bus interface. It replaces the single-byte receive register and `rda` handshake with a buffered, flow-tolerant path.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..8.
- `OVERSAMPLE`, 16: ticks per bit, even, ≥4.
- `FIFO_DEPTH`, 16: receive words, power of 2, ≥2.
- `DIV_WIDTH`, 16: divisor register width.
- `DIV_RESET`, 325: divisor after reset (50 MHz, 9600 baud, 16x).
- `PARITY_EN`, 0: 1 = parity bit follows data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rxd`  in  1  asynchronous serial input, idle high.
- `div_wr`  in  1  load `div_data` into the divisor.
- `div_data`  in  DIV_WIDTH  new divisor value.
- `rd_en`  in  1  pop the head word.
- `rd_data`  out  8  head word, zero-extended above DATA_BITS; 0 when empty.
- `rda`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  words held.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `parity_err`  out  1  sticky: parity mismatch.
- `overrun`  out  1  sticky: a word was dropped because the FIFO was full.
- `err_clr`  in  1  clear all three sticky flags.

## Operation
- `rxd` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- Tick generator:
  - Down-counter reloads with the divisor when it reaches 0 and emits a 1-cycle `tick`. Tick period is divisor+1 clocks; divisor 0 gives a tick every clock.
  - `div_wr` loads the divisor and reloads the counter in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK. `scnt` counts ticks within a bit.
  - IDLE: on a tick with `rxs`=0 → START, `scnt`=0.
  - START: at `scnt`=OVERSAMPLE/2-1, `rxs`=1 is a glitch → IDLE; `rxs`=0 → DATA with `scnt`=0 and bit index 0.
  - DATA: sample at `scnt`=OVERSAMPLE-1. Shift LSB-first. After DATA_BITS samples → PARITY if PARITY_EN, else STOP.
  - PARITY: one sample. Mismatch marks the frame bad.
  - STOP: one sample.
    - `rxs`=1 and frame good → push word, go to IDLE.
    - `rxs`=1 and parity bad → set `parity_err`, discard word, go to IDLE.
    - `rxs`=0 → set `frame_err`, discard word, go to BRK.
  - BRK: wait for `rxs`=1, then → IDLE. Prevents break or low-line retriggering.
- FIFO:
  - Push while full (without a same-cycle pop) drops the word and sets `overrun`.
  - `rd_en` while empty is ignored.
  - Push and pop in the same cycle: both occur and `count` is unchanged. This includes the full case, which does not set `overrun`.
  - Pointers wrap modulo FIFO_DEPTH. `count` saturates at FIFO_DEPTH.
- Sticky flags:
  - `err_clr` clears all three flags.
  - A set event in the same cycle as `err_clr` wins (flag ends set).
- Reset (`rst`=0 at a clock edge) clears:
  - FIFO and `count`.
  - All flags, synchronizer (to 1), state (to IDLE), tick counter.
  - Divisor returns to DIV_RESET. An in-flight frame is abandoned.

## Timing
- Reset values: `rda`=0, `count`=0, `rd_data`=0, `frame_err`=`parity_err`=`overrun`=0.
- Input latency is 2 clocks through the synchronizer.
- Push occurs on the clock of the STOP-sample tick. `rda`, `count` and `rd_data` update on the next edge.
- `rd_data` is combinational from the head entry (FWFT). After `rd_en`, the next word appears on the following edge.
- A sample point is at bit centre ± one tick period. A frame takes (1+DATA_BITS+PARITY_EN+0.5)×OVERSAMPLE ticks from start detection to push.

## Test plan
- Basic receive: divisor=3, OVERSAMPLE=16, 8N1 byte 0xA5 (64 clocks/bit) → `rda`=1 after the stop mid-sample, `rd_data`=0xA5, `count`=1. Pulse `rd_en` → `rda`=0, `rd_data`=0.
- Start glitch: `rxd` low for 20 clocks, then high → no push, FSM back in IDLE, all flags 0.
- Parity: PARITY_EN=1, even parity, send 0x03 with parity bit 1 → `parity_err`=1, `count`=0. Pulse `err_clr` → flag 0. Resend with parity 0 → 0x03 received.
- Framing/break: 0x55 with stop bit low, line held low 500 clocks → `frame_err`=1, no push, no further frames until `rxd` rises. Next 0x12 received correctly.
- Overrun and wrap: FIFO_DEPTH=4, send 0x00..0x05 without reads → `count`=4, `overrun`=1. Reads return 0x00..0x03. Repeat 3 times to cover pointer wrap. A push coincident with `rd_en` when full → `count` stays 4, `overrun` not re-set after clear.
- Reset mid-frame: assert `rst`=0 for one clock during DATA bit 3 → all outputs at reset values, divisor=DIV_RESET. The following frame is received cleanly.
